// File: rtl/regbank_arbiter_pkg.sv
// Shared constants and types for the register-bank arbiter: bank geometry,
// FSM state encoding and the latched request record.
package regbank_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(NUM_REGS);
    endfunction

endpackage

// File: rtl/regbank_arbiter_if.sv
// Requester request/response channels plus the single bank access port.
// The arbiter takes the slave view; clients and the bank sit on the master view.
interface regbank_arbiter_if
    import regbank_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic [IDX_W-1:0]          grant_id;
    logic                      busy;
    logic                      bank_write_en;
    logic                      bank_read_en;
    logic [ADDR_W-1:0]         bank_addr;
    logic [DATA_W-1:0]         bank_data_in;
    logic [DATA_W-1:0]         bank_data_out;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, bank_data_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, grant_id, busy,
               bank_write_en, bank_read_en, bank_addr, bank_data_in
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, bank_data_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, grant_id, busy,
               bank_write_en, bank_read_en, bank_addr, bank_data_in
    );

endinterface

// File: rtl/regbank_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer wins. The pointer register is owned by the caller.
module rr_arbiter #(
    parameter int  NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant_oh,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any_req
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    assign o_any_req = |i_req;

    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found            = 1'b1;
                o_grant_oh[w_idx]  = 1'b1;
                o_grant_idx        = w_idx;
            end
        end
    end

endmodule

// File: rtl/regbank_arbiter.sv
// Shares one register-bank port between NUM_REQ requesters with round-robin
// grant, a single transaction in flight, and error responses for bad addresses.
module regbank_arbiter
    import regbank_pkg::*;
#(
    parameter int  NUM_REQ  = 2,
    parameter int  READ_LAT = 1,
    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1
) (
    input logic                clk,
    input logic                rst,
    regbank_arbiter_if.slave   bus
);

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_grant_id;
    logic [NUM_REQ-1:0] r_rsp_valid;
    req_t               r_req;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_err;
    logic [CNT_W-1:0]   r_lat_cnt;

    logic [IDX_W-1:0]   w_grant_idx;
    logic [IDX_W-1:0]   w_rr_next;
    logic [NUM_REQ-1:0] w_grant_oh;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic               w_any_req;
    logic               w_accept;
    logic               w_rsp_done;
    req_t               w_sel_req;
    logic [ADDR_W-1:0]  w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  w_wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
            assign w_wdata_arr[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req       (bus.req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx),
        .o_any_req   (w_any_req)
    );

    assign w_sel_req  = '{write: bus.req_write[w_grant_idx],
                          addr:  w_addr_arr[w_grant_idx],
                          wdata: w_wdata_arr[w_grant_idx]};
    assign w_rr_next  = (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + IDX_W'(1);
    assign w_owner_oh = NUM_REQ'(1) << r_grant_id;
    assign w_accept   = (r_state == IDLE) && w_any_req;
    assign w_rsp_done = (r_state == RESP) && bus.rsp_ready[r_grant_id];

    assign bus.req_ready = w_accept ? w_grant_oh : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign bus.grant_id  = r_grant_id;
    assign bus.busy      = (r_state != IDLE);

    // The bank only ever sees the latched request, and only for the ISSUE cycle.
    assign bus.bank_write_en = (r_state == ISSUE) &&  r_req.write;
    assign bus.bank_read_en  = (r_state == ISSUE) && !r_req.write;
    assign bus.bank_addr     = (r_state == ISSUE) ? r_req.addr  : '0;
    assign bus.bank_data_in  = (r_state == ISSUE) ? r_req.wdata : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_rsp_valid <= '0;
            r_req       <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_lat_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req      <= w_sel_req;
                        r_grant_id <= w_grant_idx;
                        r_rr_ptr   <= w_rr_next;
                        r_rdata    <= '0;
                        if (addr_legal(w_sel_req.addr)) begin
                            r_err   <= 1'b0;
                            r_state <= ISSUE;
                        end else begin
                            r_err       <= 1'b1;
                            r_rsp_valid <= w_grant_oh;
                            r_state     <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    r_lat_cnt <= '0;
                    if (r_req.write) begin
                        r_rsp_valid <= w_owner_oh;
                        r_state     <= RESP;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_lat_cnt == CNT_W'(READ_LAT - 1)) begin
                        r_rdata     <= bus.bank_data_out;
                        r_rsp_valid <= w_owner_oh;
                        r_state     <= RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (w_rsp_done) begin
                        r_rsp_valid <= '0;
                        r_rdata     <= '0;
                        r_err       <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: table vectors, hand sequences for contention,
// backpressure and mid-transaction reset, then random traffic against a model.
module tb_regbank_arbiter;
    import regbank_pkg::*;

    localparam int NREQ = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regbank_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    regbank_arbiter #(.NUM_REQ(NREQ), .READ_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Bank: 14 words, write on write_en edge, data_out valid one edge after read_en.
    logic [15:0] bank_mem [14] = '{default: 16'h0000};
    logic [15:0] bank_dout = 16'h0000;
    assign bus.bank_data_out = bank_dout;
    always @(posedge clk) begin
        if (bus.bank_write_en && bus.bank_addr < 4'd14) bank_mem[bus.bank_addr] <= bus.bank_data_in;
        if (bus.bank_read_en) bank_dout <= (bus.bank_addr < 4'd14) ? bank_mem[bus.bank_addr] : 16'h0000;
    end

    int checks = 0;
    int failures = 0;

    int wr_strobes = 0, rd_strobes = 0, both_strobes = 0, bad_strobes = 0, idle_nonzero = 0;
    logic [3:0]  last_baddr = '0;
    logic [15:0] last_bdin  = '0;

    always @(negedge clk) begin
        if (rst) begin
            if (bus.bank_write_en) begin
                wr_strobes++;
                last_baddr = bus.bank_addr;
                last_bdin  = bus.bank_data_in;
            end
            if (bus.bank_read_en) rd_strobes++;
            if (bus.bank_write_en && bus.bank_read_en) both_strobes++;
            if ((bus.bank_write_en || bus.bank_read_en) && bus.bank_addr >= 4'd14) bad_strobes++;
            if (!bus.bank_write_en && !bus.bank_read_en && (bus.bank_addr != 0 || bus.bank_data_in != 0))
                idle_nonzero++;
        end
    end

    logic [15:0] model_mem [16];
    int          model_rr;

    typedef struct {
        int          rid;
        bit          wr;
        logic [3:0]  addr;
        logic [15:0] wdata;
        int          bp;
        bit          exp_err;
        logic [15:0] exp_rdata;
        int          exp_lat;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_rsp(input int rid, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid[rid] && lat < 20);
    endtask

    // Starts and ends just after a falling edge.
    task automatic run_txn(input int rid, input bit wr, input logic [3:0] addr, input logic [15:0] wdata,
                           input int bp, input bit exp_err, input logic [15:0] exp_rdata, input int exp_lat);
        int w, lat, wr0, rd0;
        bit legal;
        legal = (addr < 4'd14);
        wr0 = wr_strobes;
        rd0 = rd_strobes;
        bus.req_write[rid] = wr;
        bus.req_addr[rid*4 +: 4] = addr;
        bus.req_wdata[rid*16 +: 16] = wdata;
        bus.rsp_ready[rid] = (bp == 0);
        bus.req_valid[rid] = 1'b1;
        w = 0;
        #1;
        while (!bus.req_ready[rid] && w < 50) begin
            @(negedge clk); #1; w++;
        end
        check("accept_timeout", (w < 50), 1);
        @(posedge clk); #1;
        bus.req_valid[rid] = 1'b0;
        model_rr = (rid + 1) % NREQ;
        check("busy_after_accept", bus.busy, 1);
        check("grant_id", bus.grant_id, rid);
        wait_rsp(rid, lat);
        check("latency", lat, exp_lat);
        check("rsp_valid_onehot", bus.rsp_valid, 1 << rid);
        check("rsp_rdata", bus.rsp_rdata, exp_rdata);
        check("rsp_err", bus.rsp_err, exp_err);
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            check("bp_hold_valid", bus.rsp_valid[rid], 1);
            check("bp_hold_rdata", bus.rsp_rdata, exp_rdata);
        end
        bus.rsp_ready[rid] = 1'b1;
        @(posedge clk); #1;
        check("rsp_valid_drop", bus.rsp_valid, 0);
        check("wr_strobe_count", wr_strobes - wr0, (legal && wr) ? 1 : 0);
        check("rd_strobe_count", rd_strobes - rd0, (legal && !wr) ? 1 : 0);
        if (legal && wr) begin
            check("bank_waddr", last_baddr, addr);
            check("bank_wdata", last_bdin, wdata);
            model_mem[addr] = wdata;
        end
        $display("txn rid=%0d %s addr=%0d wdata=%h rdata=%h err=%0b lat=%0d bp=%0d",
                 rid, wr ? "WR" : "RD", addr, wdata, bus.rsp_rdata, exp_err, lat, bp);
        @(negedge clk);
    endtask

    // Expected results from the access rules: bad address errors in 1 cycle,
    // writes answer in 2, reads in 2 + READ_LAT with the stored word.
    task automatic run_model(input int rid, input bit wr, input logic [3:0] addr, input logic [15:0] wdata, input int bp);
        bit legal;
        legal = (addr < 4'd14);
        run_txn(rid, wr, addr, wdata, bp, !legal, (legal && !wr) ? model_mem[addr] : 16'h0000,
                legal ? (wr ? 2 : 2 + 1) : 1);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, lat, exp_g, seen;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = '1;
        for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
        model_rr = 0;

        // Reset held for two edges, outputs idle afterwards.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rdata", bus.rsp_rdata, 0);
        check("rst_err", bus.rsp_err, 0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_bank_we", bus.bank_write_en, 0);
        check("rst_bank_re", bus.bank_read_en, 0);
        check("rst_bank_addr", bus.bank_addr, 0);
        check("rst_bank_din", bus.bank_data_in, 0);

        for (int a = 0; a < 14; a++) vecs.push_back('{0, 1'b0, 4'(a), 16'h0000, 0, 1'b0, 16'h0000, 3});
        vecs.push_back('{0, 1'b1, 4'd5,  16'h1234, 0, 1'b0, 16'h0000, 2});
        vecs.push_back('{0, 1'b0, 4'd5,  16'h0000, 0, 1'b0, 16'h1234, 3});
        vecs.push_back('{1, 1'b0, 4'd14, 16'h0000, 0, 1'b1, 16'h0000, 1});
        vecs.push_back('{1, 1'b1, 4'd15, 16'hFFFF, 0, 1'b1, 16'h0000, 1});
        vecs.push_back('{0, 1'b1, 4'd1,  16'hFFFF, 0, 1'b0, 16'h0000, 2});
        vecs.push_back('{1, 1'b0, 4'd1,  16'h0000, 2, 1'b0, 16'hFFFF, 3});
        foreach (vecs[i])
            run_txn(vecs[i].rid, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].bp,
                    vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_lat);

        // Illegal accesses must not have disturbed any register.
        for (int a = 0; a < 14; a++) run_model(1, 1'b0, 4'(a), 16'h0000, 0);

        // Contention: both requesters valid continuously, grants must alternate.
        bus.req_write = 2'b11;
        bus.req_addr  = {4'd3, 4'd2};
        bus.req_wdata = {16'h5555, 16'hAAAA};
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b11;
        w = wr_strobes;
        for (int g = 0; g < 4; g++) begin
            int gw;
            exp_g = model_rr;
            gw = 0;
            #1;
            while (bus.req_ready == 0 && gw < 20) begin
                @(negedge clk); #1; gw++;
            end
            check($sformatf("cont_ready_%0d", g), bus.req_ready, 1 << exp_g);
            if (g > 0) check($sformatf("cont_gap_%0d", g), gw, 0);
            @(posedge clk); #1;
            if (g == 3) bus.req_valid = 2'b00;
            check($sformatf("cont_grant_%0d", g), bus.grant_id, exp_g);
            model_rr = (exp_g + 1) % NREQ;
            model_mem[exp_g == 1 ? 3 : 2] = (exp_g == 1) ? 16'h5555 : 16'hAAAA;
            wait_rsp(exp_g, lat);
            check($sformatf("cont_lat_%0d", g), lat, 2);
            check($sformatf("cont_rsp_%0d", g), bus.rsp_valid, 1 << exp_g);
            $display("txn contention grant=%0d lat=%0d", exp_g, lat);
            @(posedge clk);
            @(negedge clk);
        end
        check("cont_wr_strobes", wr_strobes - w, 4);
        run_model(0, 1'b0, 4'd2, 16'h0000, 0);
        run_model(0, 1'b0, 4'd3, 16'h0000, 0);

        // Backpressure: req1 reads reg1 with rsp_ready low for 5 cycles while req0 waits.
        bus.rsp_ready[1] = 1'b0;
        bus.req_write[1] = 1'b0;
        bus.req_addr[7:4] = 4'd1;
        bus.req_valid[1] = 1'b1;
        w = 0;
        #1;
        while (!bus.req_ready[1] && w < 20) begin
            @(negedge clk); #1; w++;
        end
        check("bp_accept", bus.req_ready, 2'b10);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        bus.req_write[0] = 1'b1;
        bus.req_addr[3:0] = 4'd9;
        bus.req_wdata[15:0] = 16'h1357;
        bus.rsp_ready[0] = 1'b1;
        bus.req_valid[0] = 1'b1;
        wait_rsp(1, lat);
        check("bp_lat", lat, 3);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("bp_valid_%0d", k), bus.rsp_valid, 2'b10);
            check($sformatf("bp_rdata_%0d", k), bus.rsp_rdata, model_mem[1]);
            check($sformatf("bp_no_grant0_%0d", k), bus.req_ready, 0);
        end
        $display("txn backpressure rid=1 RD addr=1 rdata=%h held=5", bus.rsp_rdata);
        bus.rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        check("bp_rsp_drop", bus.rsp_valid, 0);
        @(negedge clk); #1;
        check("bp_next_grant", bus.req_ready, 2'b01);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        wait_rsp(0, lat);
        check("bp_req0_lat", lat, 2);
        model_mem[9] = 16'h1357;
        model_rr = 1;
        $display("txn rid=0 WR addr=9 wdata=1357 lat=%0d", lat);
        @(posedge clk);
        @(negedge clk);
        run_model(1, 1'b0, 4'd9, 16'h0000, 0);

        // Reset during the WAIT cycle of a read drops the transaction.
        bus.req_write[0] = 1'b0;
        bus.req_addr[3:0] = 4'd7;
        bus.rsp_ready[0] = 1'b1;
        bus.req_valid[0] = 1'b1;
        w = 0;
        #1;
        while (!bus.req_ready[0] && w < 20) begin
            @(negedge clk); #1; w++;
        end
        check("rmid_accept", bus.req_ready, 2'b01);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rmid_busy_in_wait", bus.busy, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rmid_idle", bus.busy, 0);
        check("rmid_no_rsp", bus.rsp_valid, 0);
        model_rr = 0;
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid != 0) seen++;
        end
        check("rmid_no_late_rsp", seen, 0);
        $display("txn reset-mid-read rid=0 addr=7 dropped");
        run_model(0, 1'b1, 4'd7, 16'h8000, 0);
        run_model(0, 1'b0, 4'd7, 16'h0000, 0);

        for (int i = 0; i < 40; i++)
            run_model($urandom_range(0, 1), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      16'($urandom), $urandom_range(0, 2));

        check("both_strobes", both_strobes, 0);
        check("illegal_strobes", bad_strobes, 0);
        check("bank_idle_nonzero", idle_nonzero, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regbank_arbiter.md
Name: regbank_arbiter

Overview:
- Shares the 16-bit register bank (14 registers, one access port: write_en/read_en/addr/data_in/data_out) between NUM_REQ requesters.
- Each requester issues read or write transactions over a valid/ready request channel and gets results on a valid/ready response channel.
- Round-robin grant, one transaction in flight. Out-of-range addresses are rejected with an error response and never reach the bank.
- Sits between the bank and its clients (CPU-side port, DMA/debug port).

Parameters:
- NUM_REQ, 2, number of requesters.
- NUM_REGS, 14, valid bank registers; addresses >= NUM_REGS are illegal.
- ADDR_W, 4, address width.
- DATA_W, 16, data width.
- READ_LAT, 1, cycles from the bank read_en edge to valid data_out.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accept.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- rsp_valid  out  NUM_REQ  response valid; one-hot to the owner.
- rsp_ready  in  NUM_REQ  response accept.
- rsp_rdata  out  DATA_W  read data, shared; 0 for writes and errors.
- rsp_err  out  1  illegal address flag, shared.
- grant_id  out  $clog2(NUM_REQ)  current owner; valid while busy=1.
- busy  out  1  transaction in flight.
- bank_write_en  out  1  to bank write_en.
- bank_read_en  out  1  to bank read_en.
- bank_addr  out  ADDR_W  to bank addr.
- bank_data_in  out  DATA_W  to bank data_in.
- bank_data_out  in  DATA_W  from bank data_out.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; rr pointer=0; all outputs 0.
  - Any in-flight transaction is dropped: no bank strobe, no response.
  - Reset overrides every other input in that cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, pick the first requester at or after rr pointer (round-robin). Drive req_ready=1 to that requester only, combinationally, in the same cycle.
  - At the posedge: latch write/addr/wdata and the grant; set rr pointer = grant+1 mod NUM_REQ.
  - Next state: ISSUE if addr < NUM_REGS; otherwise RESP with rsp_err=1.
  - req_ready is 0 in every other state.
- ISSUE (exactly 1 cycle):
  - Drive bank_addr and bank_data_in. Assert bank_write_en or bank_read_en (never both).
  - Write: next state RESP. Read: next state WAIT.
- WAIT: count READ_LAT cycles, then capture bank_data_out into the rdata register; next state RESP.
- RESP:
  - rsp_valid[grant]=1; rsp_rdata and rsp_err are held stable until rsp_ready[grant]=1.
  - On the accept edge, go to IDLE. The next grant can occur in the cycle after RESP.
- Bank outputs are 0 outside ISSUE. No bank strobe is ever issued for an illegal address.
- Latency, from request accept edge to first rsp_valid cycle:
  - write: 2 cycles
  - read: 2+READ_LAT cycles
  - illegal: 1 cycle
- Requests held by non-granted requesters wait; do not drop them. Fairness: with 2 requesters continuously valid, grants strictly alternate.
- rsp_err=1 only with an illegal address. rsp_rdata=0 on writes and errors.
- busy=1 in ISSUE/WAIT/RESP.

Decomposition:
- Package regbank_pkg: DATA_W, ADDR_W, NUM_REGS constants; state_t enum {IDLE, ISSUE, WAIT, RESP}; request struct {write, addr, wdata}.
- Sub-module rr_arbiter: NUM_REQ-wide round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, grant index, any_req.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release → all outputs 0, busy=0. Reading regs 0..13 via requester 0 returns 0000 each, rsp_err=0.
- Single write/read: req0 writes 1234 to addr 5, then reads addr 5 → bank_write_en pulses once with addr=5, data=1234. rsp_valid comes 2 cycles after the write accept edge. Read response rdata=1234 comes 3 cycles after its accept edge.
- Contention: req0 and req1 both valid continuously, writing AAAA to reg 2 and 5555 to reg 3 → grants go 0,1,0,1 (rr starts at 0). Readback gives reg2=AAAA, reg3=5555.
- Illegal address: req1 reads addr 14, then writes FFFF to addr 15 → rsp_err=1, rdata=0000, bank strobes stay 0 throughout. A later read of every reg 0..13 shows no change.
- Backpressure: read of reg 1 (value FFFF) with rsp_ready held low 5 cycles → rsp_valid stays high with FFFF stable. req0 is not granted while req1 is valid and waiting, and the grant occurs the cycle after accept.
- Reset mid-op: assert rst=0 in the WAIT cycle of a read → next cycle state IDLE, no rsp_valid issued. A following write/read of 8000 to reg 7 works normally.
